// File: rtl/ci_pkg.sv
// Shared custom-instruction constants and master FSM state encoding,
// used by the CI initiator and the CI slave wrappers.
package ci_pkg;

    localparam int CI_DATAA_W  = 9;
    localparam int CI_DATAB_W  = 2;
    localparam int CI_RESULT_W = 32;

    typedef logic [1:0] ci_state_t;

    localparam ci_state_t IDLE  = 2'd0;
    localparam ci_state_t ISSUE = 2'd1;
    localparam ci_state_t WAIT  = 2'd2;
    localparam ci_state_t HOLD  = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ci_watchdog.sv
// Loadable down-counter that flags the last enabled cycle of a
// TIMEOUT_CYCLES window.
module ci_watchdog
    import ci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= INIT;
        end else if (en && count != '0) begin
            count <= count - ONE;
        end
    end

    assign expire = en && (count == ONE);

endmodule

// File: rtl/ci_fir_initiator.sv
// Custom-instruction master: turns a valid/ready request stream into
// CI start/wait cycles on the FIR slave and returns the result stream.
module ci_fir_initiator
    import ci_pkg::*;
#(
    parameter int DATAA_W        = CI_DATAA_W,
    parameter int DATAB_W        = CI_DATAB_W,
    parameter int RESULT_W       = CI_RESULT_W,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATAA_W-1:0]  s_dataa,
    input  logic [DATAB_W-1:0]  s_datab,
    output logic                ci_clk_en,
    output logic                ci_start,
    output logic [DATAA_W-1:0]  ci_dataa,
    output logic [DATAB_W-1:0]  ci_datab,
    input  logic [RESULT_W-1:0] ci_result,
    input  logic [RESULT_W-1:0] ci_resultc,
    input  logic                ci_done,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RESULT_W-1:0] m_result,
    output logic [RESULT_W-1:0] m_resultc,
    output logic                m_timeout,
    output logic                busy,
    output logic [7:0]          err_count
);

    ci_state_t state;
    logic      accept;
    logic      wd_expire;

    // A HOLD handshake may chain straight into the next request.
    assign s_ready = (state == IDLE) || (state == HOLD && m_ready);
    assign accept  = s_valid && s_ready;
    assign busy    = (state != IDLE);

    ci_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .load  (state == ISSUE),
        .en    (state == WAIT),
        .expire(wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ci_clk_en <= 1'b0;
            ci_start  <= 1'b0;
            ci_dataa  <= '0;
            ci_datab  <= '0;
            m_valid   <= 1'b0;
            m_result  <= '0;
            m_resultc <= '0;
            m_timeout <= 1'b0;
            err_count <= '0;
        end else begin
            ci_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ci_dataa  <= s_dataa;
                        ci_datab  <= s_datab;
                        ci_start  <= 1'b1;
                        ci_clk_en <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // done beats a simultaneous watchdog expiry
                    if (ci_done) begin
                        m_result  <= ci_result;
                        m_resultc <= ci_resultc;
                        m_timeout <= 1'b0;
                        m_valid   <= 1'b1;
                        ci_clk_en <= 1'b0;
                        state     <= HOLD;
                    end else if (wd_expire) begin
                        m_result  <= '0;
                        m_resultc <= '0;
                        m_timeout <= 1'b1;
                        m_valid   <= 1'b1;
                        ci_clk_en <= 1'b0;
                        err_count <= sat_inc8(err_count);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                    if (accept) begin
                        ci_dataa  <= s_dataa;
                        ci_datab  <= s_datab;
                        ci_start  <= 1'b1;
                        ci_clk_en <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
